// File: rtl/game_state_ctrl.sv
// -----------------------------------------------------------------------------
// game_state_ctrl
//
// Game-flow controller. It watches the per-pixel drawing requests coming out of
// the object layers and the background border layer, accumulates collisions over
// a video frame, and resolves them once per frame on startOfFrame. It owns the
// lives counter, the post-hit immunity window, the end-screen hold time and the
// start key handling, and drives the end-game overlay enables.
//
// Ports
//   clk               system clock
//   resetN            asynchronous active-low reset (async assert, sync release)
//   startOfFrame      one-cycle pulse at the start of each video frame
//   playerDR          player object drawing request for the current pixel
//   enemy_bulletDR    enemy bullet drawing request for the current pixel
//   enemyDR           any-enemy drawing request for the current pixel
//   bordersDR[1:0]    [0] movement-zone borders (unused here), [1] player-zone line
//   all_enemies_dead  level, high once the enemy matrix is empty
//   start_key         start key level, already synchronised to clk
//   game_active       high while a game is being played
//   game_won          high on the win screen (selects overlay colour)
//   game_over         high on the win or lose screen (overlay enable)
//   lives             remaining lives
//   player_hit        one-cycle pulse when a life is taken
//   restart           one-cycle pulse when a new game begins
//
// All outputs are registered and change on the edge that samples startOfFrame
// (or the start key press).
// -----------------------------------------------------------------------------
module game_state_ctrl #(
  parameter int unsigned INITIAL_LIVES   = 3,
  parameter int unsigned LIVES_WIDTH     = 3,
  parameter int unsigned INVULN_FRAMES   = 60,
  parameter int unsigned END_HOLD_FRAMES = 120,
  parameter int unsigned FRAME_CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   playerDR,
  input  logic                   enemy_bulletDR,
  input  logic                   enemyDR,
  input  logic [1:0]             bordersDR,
  input  logic                   all_enemies_dead,
  input  logic                   start_key,
  output logic                   game_active,
  output logic                   game_won,
  output logic                   game_over,
  output logic [LIVES_WIDTH-1:0] lives,
  output logic                   player_hit,
  output logic                   restart
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PLAYING = 2'd1;
  localparam logic [1:0] S_WON     = 2'd2;
  localparam logic [1:0] S_LOST    = 2'd3;

  localparam logic [LIVES_WIDTH-1:0]     LIVES_INIT = LIVES_WIDTH'(INITIAL_LIVES);
  localparam logic [LIVES_WIDTH-1:0]     LIVES_ONE  = LIVES_WIDTH'(1);
  localparam logic [FRAME_CNT_WIDTH-1:0] CNT_INVULN = FRAME_CNT_WIDTH'(INVULN_FRAMES);
  localparam logic [FRAME_CNT_WIDTH-1:0] CNT_HOLD   = FRAME_CNT_WIDTH'(END_HOLD_FRAMES);
  localparam logic [FRAME_CNT_WIDTH-1:0] CNT_ONE    = FRAME_CNT_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]                 state;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;    // immunity in PLAYING, hold in WON/LOST
  logic                       hit_flag;     // bullet touched player this frame
  logic                       invade_flag;  // enemy reached the player-zone line
  logic                       key_prev;     // start_key sampled last cycle
  logic                       key_armed;    // start_key seen low since reset

  // Next-state values
  logic [1:0]                 state_n;
  logic [LIVES_WIDTH-1:0]     lives_n;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_n;
  logic                       hit_flag_n;
  logic                       invade_flag_n;
  logic                       player_hit_n;
  logic                       restart_n;

  // ---------------------------------------------------------------------------
  // Per-pixel events and helpers
  // ---------------------------------------------------------------------------
  logic                       pix_hit;
  logic                       pix_invade;
  logic                       press;
  logic                       cnt_zero;
  logic [FRAME_CNT_WIDTH-1:0] cnt_dec;

  // The movement-zone border is consumed by the object blocks, not here.
  logic unused_border_zone;
  assign unused_border_zone = bordersDR[0];

  assign pix_hit    = playerDR & enemy_bulletDR;
  assign pix_invade = enemyDR & bordersDR[1];

  // A press needs a genuine low->high transition observed after reset; a key
  // held down through reset must be released first, hence key_armed.
  assign press = start_key & ~key_prev & key_armed;

  assign cnt_zero = (frame_cnt == '0);
  assign cnt_dec  = cnt_zero ? frame_cnt : frame_cnt - CNT_ONE;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned;
    // a missing default in a combinational block infers a latch.
    state_n       = state;
    lives_n       = lives;
    frame_cnt_n   = frame_cnt;
    hit_flag_n    = hit_flag;
    invade_flag_n = invade_flag;
    player_hit_n  = 1'b0;
    restart_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (press) begin
          state_n       = S_PLAYING;
          lives_n       = LIVES_INIT;
          frame_cnt_n   = '0;
          hit_flag_n    = 1'b0;
          invade_flag_n = 1'b0;
          restart_n     = 1'b1;
        end
      end

      S_PLAYING: begin
        if (startOfFrame) begin
          // Resolve the frame that just ended using the registered flags; the
          // pixel on this cycle already belongs to the new frame.
          hit_flag_n    = pix_hit;
          invade_flag_n = pix_invade;
          frame_cnt_n   = cnt_dec;

          if (invade_flag) begin
            state_n     = S_LOST;
            frame_cnt_n = CNT_HOLD;
          end else if (hit_flag && cnt_zero) begin
            // Immunity is judged on the pre-decrement count, then reloaded.
            player_hit_n = 1'b1;
            if (lives <= LIVES_ONE) begin
              lives_n     = '0;
              state_n     = S_LOST;
              frame_cnt_n = CNT_HOLD;
            end else begin
              lives_n     = lives - LIVES_ONE;
              frame_cnt_n = CNT_INVULN;
              if (all_enemies_dead) begin
                state_n     = S_WON;
                frame_cnt_n = CNT_HOLD;
              end
            end
          end else if (all_enemies_dead) begin
            state_n     = S_WON;
            frame_cnt_n = CNT_HOLD;
          end
        end else begin
          hit_flag_n    = hit_flag | pix_hit;
          invade_flag_n = invade_flag | pix_invade;
        end
      end

      S_WON, S_LOST: begin
        // The end screen is held until the counter runs out; only then does a
        // press start a new game.
        if (press && cnt_zero) begin
          state_n       = S_PLAYING;
          lives_n       = LIVES_INIT;
          frame_cnt_n   = '0;
          hit_flag_n    = 1'b0;
          invade_flag_n = 1'b0;
          restart_n     = 1'b1;
        end else if (startOfFrame) begin
          frame_cnt_n = cnt_dec;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= S_IDLE;
      lives       <= LIVES_INIT;
      frame_cnt   <= '0;
      hit_flag    <= 1'b0;
      invade_flag <= 1'b0;
      key_prev    <= 1'b0;
      key_armed   <= 1'b0;
      player_hit  <= 1'b0;
      restart     <= 1'b0;
      game_active <= 1'b0;
      game_won    <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state       <= state_n;
      lives       <= lives_n;
      frame_cnt   <= frame_cnt_n;
      hit_flag    <= hit_flag_n;
      invade_flag <= invade_flag_n;
      key_prev    <= start_key;
      key_armed   <= key_armed | ~start_key;
      player_hit  <= player_hit_n;
      restart     <= restart_n;
      game_active <= (state_n == S_PLAYING);
      game_won    <= (state_n == S_WON);
      game_over   <= (state_n == S_WON) || (state_n == S_LOST);
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_state_ctrl
//
// Self-checking bench for game_state_ctrl. A behavioural model tracks the game
// in terms of "mode", remaining lives, frames of immunity left and frames of
// end-screen hold left; a compare process checks every DUT output against it on
// each falling edge. Directed scenarios pin the model with literal values, then
// a randomized phase exercises the same rules.
// -----------------------------------------------------------------------------
module tb_game_state_ctrl;

  localparam int FL = 10;  // clock cycles per video frame in this bench

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_WON  = 2;
  localparam int M_LOST = 3;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       sof = 1'b0;
  logic       pdr = 1'b0;
  logic       bdr = 1'b0;
  logic       edr = 1'b0;
  logic [1:0] bord = 2'b00;
  logic       aed = 1'b0;
  logic       key = 1'b0;

  logic       game_active;
  logic       game_won;
  logic       game_over;
  logic [2:0] lives;
  logic       player_hit;
  logic       restart;

  game_state_ctrl dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (sof),
    .playerDR         (pdr),
    .enemy_bulletDR   (bdr),
    .enemyDR          (edr),
    .bordersDR        (bord),
    .all_enemies_dead (aed),
    .start_key        (key),
    .game_active      (game_active),
    .game_won         (game_won),
    .game_over        (game_over),
    .lives            (lives),
    .player_hit       (player_hit),
    .restart          (restart)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_mode, m_lives, m_immune, m_hold;
  bit m_hit, m_invade, m_prev, m_armed, m_phit, m_restart;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_mode = M_IDLE; m_lives = 3; m_immune = 0; m_hold = 0;
      m_hit = 0; m_invade = 0; m_prev = 0; m_armed = 0; m_phit = 0; m_restart = 0;
    end else begin
      bit pressed, took_life, old_hit, old_invade;
      pressed = key && !m_prev && m_armed;
      m_prev = key;
      if (!key) m_armed = 1;
      m_phit = 0;
      m_restart = 0;
      if ((m_mode == M_IDLE && pressed) ||
          ((m_mode == M_WON || m_mode == M_LOST) && pressed && m_hold == 0)) begin
        m_mode = M_PLAY; m_lives = 3; m_immune = 0; m_hit = 0; m_invade = 0; m_restart = 1;
      end else if (m_mode == M_WON || m_mode == M_LOST) begin
        if (sof && m_hold > 0) m_hold--;
      end else if (m_mode == M_PLAY) begin
        if (sof) begin
          old_hit = m_hit; old_invade = m_invade;
          m_hit = pdr && bdr;
          m_invade = edr && bord[1];
          took_life = old_hit && (m_immune == 0);
          if (m_immune > 0) m_immune--;
          if (old_invade) begin
            m_mode = M_LOST; m_hold = 120;
          end else begin
            if (took_life) begin
              m_phit = 1;
              m_lives = (m_lives > 0) ? m_lives - 1 : 0;
              m_immune = 60;
            end
            if (took_life && m_lives == 0) begin
              m_mode = M_LOST; m_hold = 120;
            end else if (aed) begin
              m_mode = M_WON; m_hold = 120;
            end
          end
        end else begin
          m_hit = m_hit || (pdr && bdr);
          m_invade = m_invade || (edr && bord[1]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("game_active", {31'd0, game_active}, {31'd0, m_mode == M_PLAY});
      check("game_won",    {31'd0, game_won},    {31'd0, m_mode == M_WON});
      check("game_over",   {31'd0, game_over},   {31'd0, m_mode == M_WON || m_mode == M_LOST});
      check("lives",       {29'd0, lives},       32'(m_lives));
      check("player_hit",  {31'd0, player_hit},  {31'd0, m_phit});
      check("restart",     {31'd0, restart},     {31'd0, m_restart});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic sof_cycle();
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  task automatic frame_body(input int hits, input logic [1:0] enemy_border);
    for (int i = 1; i < FL; i++) begin
      pdr  = (i <= hits);
      bdr  = (i <= hits);
      edr  = (enemy_border != 2'b00) && (i == 2);
      bord = (i == 2) ? enemy_border : 2'b00;
      @(negedge clk);
    end
    pdr = 1'b0; bdr = 1'b0; edr = 1'b0; bord = 2'b00;
  endtask

  task automatic quiet_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_body(0, 2'b00);
      sof_cycle();
    end
  endtask

  task automatic press_expect(input bit accepted);
    key = 1'b1;
    @(negedge clk);
    check("press_restart", {31'd0, restart}, {31'd0, accepted});
    if (accepted) begin
      check("press_lives", {29'd0, lives}, 32'd3);
      check("press_active", {31'd0, game_active}, 32'd1);
      check("press_over", {31'd0, game_over}, 32'd0);
    end
    key = 1'b0;
    @(negedge clk);
    check("restart_one_cycle", {31'd0, restart}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios, then randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    #1 resetN = 1'b0;
    #1 cmp_en = 1'b1;
    @(negedge clk);
    check("rst_lives", {29'd0, lives}, 32'd3);
    check("rst_active", {31'd0, game_active}, 32'd0);
    check("rst_over", {31'd0, game_over}, 32'd0);
    @(negedge clk);
    #2 resetN = 1'b1;
    repeat (3) @(negedge clk);

    // Start a game.
    press_expect(1'b1);

    // Hit in frame N costs a life at the next frame start.
    quiet_frames(1);
    frame_body(5, 2'b00);
    sof_cycle();
    check("hit1_lives", {29'd0, lives}, 32'd2);
    check("hit1_pulse", {31'd0, player_hit}, 32'd1);
    @(negedge clk);
    check("hit1_pulse_end", {31'd0, player_hit}, 32'd0);

    // Hit during immunity is discarded.
    frame_body(5, 2'b00);
    sof_cycle();
    check("immune_lives", {29'd0, lives}, 32'd2);
    check("immune_nopulse", {31'd0, player_hit}, 32'd0);

    // Immunity covers 60 resolutions; the 61st accepts a hit.
    quiet_frames(59);
    frame_body(5, 2'b00);
    sof_cycle();
    check("hit2_lives", {29'd0, lives}, 32'd1);

    // Fatal hit together with all enemies dead resolves to LOST.
    quiet_frames(60);
    aed = 1'b1;
    frame_body(5, 2'b00);
    sof_cycle();
    aed = 1'b0;
    check("fatal_over", {31'd0, game_over}, 32'd1);
    check("fatal_won", {31'd0, game_won}, 32'd0);
    check("fatal_lives", {29'd0, lives}, 32'd0);
    check("fatal_pulse", {31'd0, player_hit}, 32'd1);

    quiet_frames(120);
    press_expect(1'b1);

    // Movement-zone border is ignored; player-zone line means invasion.
    frame_body(0, 2'b01);
    sof_cycle();
    check("border0_active", {31'd0, game_active}, 32'd1);
    frame_body(0, 2'b10);
    sof_cycle();
    check("invade_over", {31'd0, game_over}, 32'd1);
    check("invade_won", {31'd0, game_won}, 32'd0);
    check("invade_lives", {29'd0, lives}, 32'd3);

    quiet_frames(120);
    press_expect(1'b1);

    // Win, early press ignored, late press restarts.
    aed = 1'b1;
    frame_body(0, 2'b00);
    sof_cycle();
    aed = 1'b0;
    check("won_won", {31'd0, game_won}, 32'd1);
    check("won_over", {31'd0, game_over}, 32'd1);
    quiet_frames(50);
    press_expect(1'b0);
    check("won_still", {31'd0, game_won}, 32'd1);
    quiet_frames(70);
    press_expect(1'b1);

    // Collision on the startOfFrame cycle belongs to the next frame.
    quiet_frames(1);
    pdr = 1'b1; bdr = 1'b1;
    sof_cycle();
    pdr = 1'b0; bdr = 1'b0;
    check("edge_hit_not_now", {29'd0, lives}, 32'd3);
    frame_body(0, 2'b00);
    sof_cycle();
    check("edge_hit_next", {29'd0, lives}, 32'd2);

    // Reset mid-game with the key held through it.
    key = 1'b1;
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check("midrst_active", {31'd0, game_active}, 32'd0);
    check("midrst_lives", {29'd0, lives}, 32'd3);
    check("midrst_over", {31'd0, game_over}, 32'd0);
    check("midrst_restart", {31'd0, restart}, 32'd0);
    repeat (2) @(negedge clk);
    #2 resetN = 1'b1;
    repeat (3) @(negedge clk);
    check("held_key_nopress", {31'd0, game_active}, 32'd0);
    key = 1'b0;
    @(negedge clk);
    press_expect(1'b1);

    // Randomized traffic against the model.
    for (int c = 0; c < 12000; c++) begin
      sof  = (c % FL == 0);
      pdr  = ($urandom_range(0, 5) == 0);
      bdr  = ($urandom_range(0, 5) == 0);
      edr  = ($urandom_range(0, 200) == 0);
      bord = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 400) == 0) aed = ~aed;
      if ($urandom_range(0, 40) == 0) key = ~key;
      @(negedge clk);
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
